// File: rtl/simple_dma_controller.sv
// simple_dma_controller: controller side of the simple DMA device handshake.
// Moves 16-bit words between one DMA device and memory over the openMSP430
// DMA master port, one word per device handshake, then pulses an end flag and
// waits for the device to release its request.
// Optional build macro DMA_ERR_ABORT_EN: a memory access answered with
// dma_resp aborts the transfer and raises the sticky dma_error flag.
module simple_dma_controller #(
    parameter logic PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dev_rqst,
    input  logic        dev_rd_wr,
    input  logic [15:0] dev_start_addr,
    input  logic [15:0] dev_num_words,
    input  logic        dev_ack,
    input  logic [15:0] dev_wdata,
    output logic [15:0] dev_rdata,
    output logic        dev_dma_ack,
    output logic        dev_end_flag,
    output logic [14:0] dma_addr,
    output logic [15:0] dma_din,
    output logic        dma_en,
    output logic [1:0]  dma_we,
    output logic        dma_priority,
    output logic        dma_wkup,
    input  logic [15:0] dma_dout,
    input  logic        dma_ready,
    input  logic        dma_resp,
    output logic        dma_error
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_DATA,
        S_RD_DEV,
        S_WR_DEV,
        S_WR_REQ,
        S_DONE,
        S_WAIT_REL
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_waddr;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   r_wdata;

    logic w_start;
    logic w_acc_ok;
    logic w_err_hit;
    logic w_word_done;
    logic w_last;
    logic w_unused;

    // Byte address bit 0 is meaningless for word transfers; the word address is
    // kept directly so +1 here equals +2 on the byte address, wrapping mod 2^16.
    assign w_unused    = ^{dev_start_addr[0], dma_resp};

    assign w_start     = (r_state == S_IDLE) && dev_rqst;
    assign w_acc_ok    = ((r_state == S_RD_REQ) || (r_state == S_WR_REQ)) && dma_ready;
`ifdef DMA_ERR_ABORT_EN
    assign w_err_hit   = w_acc_ok && dma_resp;
`else
    assign w_err_hit   = 1'b0;
`endif
    assign w_word_done = ((r_state == S_RD_DEV) && dev_ack) ||
                         ((r_state == S_WR_REQ) && dma_ready && !w_err_hit);
    assign w_last      = (r_cnt == CNT_W'(1));

    assign dev_rdata    = r_rdata;
    assign dma_priority = PRIORITY;
    assign dma_wkup     = (r_state != S_IDLE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake/memory-port outputs
    always_comb begin
        w_state_nxt  = r_state;
        dma_en       = 1'b0;
        dma_we       = 2'b00;
        dma_addr     = '0;
        dma_din      = '0;
        dev_dma_ack  = 1'b0;
        dev_end_flag = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dev_rqst) begin
                    if (dev_num_words == '0) begin
                        w_state_nxt = S_DONE;
                    end else if (dev_rd_wr) begin
                        w_state_nxt = S_RD_REQ;
                    end else begin
                        w_state_nxt = S_WR_DEV;
                    end
                end
            end
            S_RD_REQ: begin
                dma_en   = 1'b1;
                dma_addr = r_waddr;
                if (dma_ready) begin
                    w_state_nxt = w_err_hit ? S_DONE : S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                w_state_nxt = S_RD_DEV;
            end
            S_RD_DEV: begin
                dev_dma_ack = dev_ack;
                if (dev_ack) begin
                    w_state_nxt = w_last ? S_DONE : S_RD_REQ;
                end
            end
            S_WR_DEV: begin
                dev_dma_ack = dev_ack;
                if (dev_ack) begin
                    w_state_nxt = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                dma_en   = 1'b1;
                dma_we   = 2'b11;
                dma_addr = r_waddr;
                dma_din  = r_wdata;
                if (dma_ready) begin
                    w_state_nxt = (w_err_hit || w_last) ? S_DONE : S_WR_DEV;
                end
            end
            S_DONE: begin
                dev_end_flag = 1'b1;
                w_state_nxt  = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (!dev_rqst) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Transfer address/count and word buffers in both directions
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_waddr <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_wdata <= '0;
        end else begin
            if (w_start) begin
                r_waddr <= dev_start_addr[15:1];
                r_cnt   <= dev_num_words;
            end
            if (w_word_done) begin
                r_waddr <= r_waddr + ADDR_W'(1);
                r_cnt   <= r_cnt - CNT_W'(1);
            end
            if (r_state == S_RD_DATA) begin
                r_rdata <= dma_dout;
            end
            if ((r_state == S_WR_DEV) && dev_ack) begin
                r_wdata <= dev_wdata;
            end
        end
    end

`ifdef DMA_ERR_ABORT_EN
    logic r_error;

    // Sticky access-error flag, cleared when the next transfer starts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_err_hit) begin
            r_error <= 1'b1;
        end else if (w_start) begin
            r_error <= 1'b0;
        end
    end

    assign dma_error = r_error;
`else
    assign dma_error = 1'b0;
`endif

endmodule

// File: tb/tb_simple_dma_controller.sv
// Scoreboard bench for simple_dma_controller: a transfer-level model queues
// the expected memory accesses and device words; a monitor pops and compares.
module tb_simple_dma_controller;

    typedef struct packed {
        logic [14:0] addr;
        logic [1:0]  we;
        logic [15:0] din;
    } mem_exp_t;

    typedef struct packed {
        logic        rd;
        logic [15:0] data;
    } dev_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dev_rqst = 1'b0;
    logic        dev_rd_wr = 1'b0;
    logic [15:0] dev_start_addr = '0;
    logic [15:0] dev_num_words = '0;
    logic        dev_ack = 1'b0;
    logic [15:0] dev_wdata = '0;
    logic [15:0] dev_rdata;
    logic        dev_dma_ack;
    logic        dev_end_flag;
    logic [14:0] dma_addr;
    logic [15:0] dma_din;
    logic        dma_en;
    logic [1:0]  dma_we;
    logic        dma_priority;
    logic        dma_wkup;
    logic [15:0] dma_dout = '0;
    logic        dma_ready = 1'b0;
    logic        dma_resp = 1'b0;
    logic        dma_error;

    simple_dma_controller #(.PRIORITY(1'b0)) dut (
        .clk(clk), .reset(reset),
        .dev_rqst(dev_rqst), .dev_rd_wr(dev_rd_wr),
        .dev_start_addr(dev_start_addr), .dev_num_words(dev_num_words),
        .dev_ack(dev_ack), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata),
        .dev_dma_ack(dev_dma_ack), .dev_end_flag(dev_end_flag),
        .dma_addr(dma_addr), .dma_din(dma_din), .dma_en(dma_en), .dma_we(dma_we),
        .dma_priority(dma_priority), .dma_wkup(dma_wkup), .dma_dout(dma_dout),
        .dma_ready(dma_ready), .dma_resp(dma_resp), .dma_error(dma_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    mem_exp_t    exp_mem[$];
    dev_exp_t    exp_dev[$];
    logic [15:0] wlist[$];
    logic [15:0] wq[$];
    int          ack_cyc_q[$];
    int          end_cyc_q[$];

    logic [15:0] mem[32768];
    bit          mvalid[32768];

    int cyc = 0;
    int acc_cnt = 0;
    int w_idx = 0;
    int pend_tag = 0;
    logic [15:0] pend_data = '0;
    bit prev_stall = 0;
    logic [32:0] prev_bus = '0;

    int ready_mode = 1;
    int ack_mode = 1;
    int err_at = -1;
    int wbase = 0;
    int t_start, t_ab, t_eb;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Unwritten memory returns an address-derived pattern
    function automatic logic [15:0] rd_mem(input logic [14:0] a);
        logic [15:0] v;
        if (mvalid[a]) v = mem[a];
        else           v = 16'({1'b0, a} * 16'h9E37) ^ 16'h5A5A;
        return v;
    endfunction

    // Memory and device model: drives inputs just after each rising edge
    int run = 0;
    int last_tag = 0;
    always @(posedge clk) begin
        #1;
        if (pend_tag != last_tag) begin
            dma_dout = pend_data;
            last_tag = pend_tag;
        end else begin
            dma_dout = 16'($urandom);
        end
        if ((w_idx - wbase) < wlist.size()) dev_wdata = wlist[w_idx - wbase];
        else                                dev_wdata = 16'($urandom);
        case (ack_mode)
            1:       dev_ack = 1'b1;
            2:       dev_ack = 1'b0;
            default: dev_ack = 1'($urandom_range(0, 1));
        endcase
        if (dma_en) begin
            case (ready_mode)
                1:       dma_ready = 1'b1;
                2:       dma_ready = (run >= 5);
                default: dma_ready = 1'($urandom_range(0, 1));
            endcase
            run = dma_ready ? 0 : run + 1;
        end else begin
            run = 0;
            dma_ready = 1'($urandom_range(0, 1));
        end
`ifdef DMA_ERR_ABORT_EN
        dma_resp = dma_en && dma_ready && (err_at >= 0) && (acc_cnt == err_at);
`else
        dma_resp = 1'($urandom_range(0, 1));
`endif
    end

    // Monitor: pops expectations whenever the DUT presents an access or handshake
    always @(negedge clk) begin
        mem_exp_t e;
        dev_exp_t d;
        cyc++;
        if (reset) begin
            exp_mem.delete();
            exp_dev.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_en_held", 64'(dma_en), 64'(1));
                chk("stall_bus_held", 64'({dma_addr, dma_we, dma_din}), 64'(prev_bus));
            end
            prev_stall = dma_en && !dma_ready;
            prev_bus = {dma_addr, dma_we, dma_din};
            if (dma_en && dma_ready) begin
                chk("access_expected", 64'(exp_mem.size() != 0), 64'(1));
                if (exp_mem.size() != 0) begin
                    e = exp_mem.pop_front();
                    chk("acc_addr", 64'(dma_addr), 64'(e.addr));
                    chk("acc_we", 64'(dma_we), 64'(e.we));
                    if (e.we != 2'b00) chk("acc_din", 64'(dma_din), 64'(e.din));
                end
                if (dma_we == 2'b11) begin
                    mem[dma_addr] = dma_din;
                    mvalid[dma_addr] = 1;
                end else begin
                    pend_data = rd_mem(dma_addr);
                    pend_tag++;
                end
                acc_cnt++;
            end
            if (dev_dma_ack) begin
                ack_cyc_q.push_back(cyc);
                chk("handshake_expected", 64'(exp_dev.size() != 0), 64'(1));
                if (exp_dev.size() != 0) begin
                    d = exp_dev.pop_front();
                    if (d.rd) chk("dev_rdata", 64'(dev_rdata), 64'(d.data));
                    else      w_idx++;
                end
            end
            if (dev_end_flag) end_cyc_q.push_back(cyc);
        end
    end

    // Transfer-level reference: which words move and where, given the request
    task automatic start_xfer(input logic [15:0] sa, input int n, input bit rd, input int errk);
        logic [15:0] ba, a16;
        int nacc, ndev;
        mem_exp_t e;
        dev_exp_t d;
        wlist.delete();
        for (int k = 0; k < n; k++) wlist.push_back((k < wq.size()) ? wq[k] : 16'($urandom));
        wq.delete();
        nacc = n;
        ndev = n;
`ifdef DMA_ERR_ABORT_EN
        if (errk >= 0 && errk < n) begin
            nacc = errk + 1;
            ndev = rd ? errk : errk + 1;
        end
`endif
        ba = sa & 16'hFFFE;
        for (int k = 0; k < nacc; k++) begin
            a16 = ba + 16'(2 * k);
            e.addr = a16[15:1];
            e.we = rd ? 2'b00 : 2'b11;
            e.din = rd ? 16'h0 : wlist[k];
            exp_mem.push_back(e);
        end
        for (int k = 0; k < ndev; k++) begin
            a16 = ba + 16'(2 * k);
            d.rd = rd;
            d.data = rd ? rd_mem(a16[15:1]) : 16'h0;
            exp_dev.push_back(d);
        end
        wbase = w_idx;
        err_at = (errk >= 0) ? acc_cnt + errk : -1;
        t_start = cyc;
        t_ab = ack_cyc_q.size();
        t_eb = end_cyc_q.size();
        dev_start_addr = sa;
        dev_num_words = 16'(n);
        dev_rd_wr = rd;
        dev_rqst = 1'b1;
    endtask

    task automatic scramble();
        dev_start_addr = 16'($urandom);
        dev_num_words = 16'($urandom);
        dev_rd_wr = 1'($urandom_range(0, 1));
    endtask

    task automatic finish_xfer(input int hold, output int lat_ack, output int lat_end);
        bit got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge clk); #1;
            if (end_cyc_q.size() > t_eb) got = 1;
            else scramble();
        end
        chk("end_seen", 64'(got), 64'(1));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            scramble();
        end
        dev_rqst = 1'b0;
        @(posedge clk); #1;
        err_at = -1;
        chk("end_pulse_count", 64'(end_cyc_q.size() - t_eb), 64'(1));
        chk("mem_q_drained", 64'(exp_mem.size()), 64'(0));
        chk("dev_q_drained", 64'(exp_dev.size()), 64'(0));
        chk("idle_wkup", 64'(dma_wkup), 64'(0));
        lat_ack = (ack_cyc_q.size() > t_ab) ? ack_cyc_q[t_ab] - t_start : -1;
        lat_end = (end_cyc_q.size() > t_eb) ? end_cyc_q[t_eb] - t_start : -1;
    endtask

    task automatic run_xfer(input logic [15:0] sa, input int n, input bit rd, input int hold,
                            input int errk, output int la, output int le);
        start_xfer(sa, n, rd, errk);
        @(posedge clk); #1;
        finish_xfer(hold, la, le);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int la, le, base, eb0;
        bit seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({dev_rdata, dev_dma_ack, dev_end_flag, dma_addr, dma_din,
                                  dma_en, dma_we, dma_wkup, dma_error}), 64'(0));
        chk("reset_priority", 64'(dma_priority), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Write 3 known words, then read them back with immediate handshakes
        ready_mode = 1; ack_mode = 1;
        wq = '{16'h1111, 16'h2222, 16'h3333};
        run_xfer(16'h0200, 3, 0, 0, -1, la, le);
        chk("wr_first_ack_latency", 64'(la), 64'(2));
        run_xfer(16'h0200, 3, 1, 0, -1, la, le);
        chk("rd_first_ack_latency", 64'(la), 64'(4));

        // Constant-data write
        wq = '{16'h7777, 16'h7777};
        run_xfer(16'h0300, 2, 0, 0, -1, la, le);
        chk("mem_0x180", 64'(rd_mem(15'h180)), 64'(16'h7777));
        chk("mem_0x181", 64'(rd_mem(15'h181)), 64'(16'h7777));

        // Odd start address: bit 0 ignored
        run_xfer(16'h0201, 1, 1, 0, -1, la, le);

        // Five-cycle memory stalls with a toggling device
        ready_mode = 2; ack_mode = 0;
        run_xfer(16'h0800, 3, 1, 1, -1, la, le);
        run_xfer(16'h0900, 3, 0, 2, -1, la, le);

        // Zero words: end pulse only; request held afterwards must not restart
        ready_mode = 1; ack_mode = 1;
        run_xfer(16'h1234, 0, 1, 4, -1, la, le);
        chk("zero_end_latency", 64'(le), 64'(2));

        // Address wrap at the top of memory
        run_xfer(16'hFFFE, 2, 1, 0, -1, la, le);

        // Reset while waiting for the device in the read path
        ack_mode = 2;
        eb0 = end_cyc_q.size();
        base = acc_cnt;
        start_xfer(16'h0400, 3, 1, -1);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (acc_cnt > base) seen = 1;
        end
        chk("first_read_accepted", 64'(seen), 64'(1));
        @(posedge clk); #1;
        chk("stuck_in_rd_dev_wkup", 64'(dma_wkup), 64'(1));
        reset = 1'b1;
        dev_rqst = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", 64'({dev_rdata, dev_dma_ack, dev_end_flag, dma_addr, dma_din,
                                     dma_en, dma_we, dma_wkup, dma_error}), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        chk("no_end_on_reset", 64'(end_cyc_q.size() - eb0), 64'(0));
        ack_mode = 0;
        run_xfer(16'h0500, 2, 1, 0, -1, la, le);

`ifdef DMA_ERR_ABORT_EN
        // Error on the second of four read accesses
        ready_mode = 1; ack_mode = 1;
        base = ack_cyc_q.size();
        run_xfer(16'h0600, 4, 1, 0, 1, la, le);
        chk("err_flag_set", 64'(dma_error), 64'(1));
        chk("err_handshakes", 64'(ack_cyc_q.size() - base), 64'(1));
        run_xfer(16'h0700, 2, 0, 0, -1, la, le);
        chk("err_flag_cleared", 64'(dma_error), 64'(0));
`endif

        // Randomised transfers with random stalls and device pacing
        for (int t = 0; t < 30; t++) begin
            logic [15:0] sa;
            int n, errk;
            ready_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
            ack_mode = 0;
            sa = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
            n = $urandom_range(0, 6);
            errk = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1;
            run_xfer(sa, n, 1'($urandom_range(0, 1)), $urandom_range(0, 3), errk, la, le);
        end
`ifndef DMA_ERR_ABORT_EN
        chk("error_tied_low", 64'(dma_error), 64'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
